// File: rtl/fir_out_mem_reader_pkg.sv
// Shared constants, FSM encoding and the round/shift/saturate function for the
// filter-output memory readback engine.
package fir_out_mem_reader_pkg;

    localparam int DEF_DATA_W = 22;
    localparam int DEF_OUT_W  = 16;
    localparam int DEF_SHIFT  = 6;
    localparam int ADDR_W     = 8;
    localparam int RA_W       = 6;
    localparam int CA_W       = 2;
    localparam int LEN_W      = 9;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_READ   = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    // Saturation limits expressed in the widened (DATA_W+1) arithmetic domain.
    localparam logic signed [DEF_DATA_W:0] SAT_MAX = (DEF_DATA_W+1)'(2**(DEF_OUT_W-1) - 1);
    localparam logic signed [DEF_DATA_W:0] SAT_MIN = (DEF_DATA_W+1)'(-(2**(DEF_OUT_W-1)));

    typedef struct packed {
        logic                 sat;
        logic [DEF_OUT_W-1:0] data;
    } sample_t;

    // Round half up, arithmetic shift right, then clip to the signed output range.
    function automatic sample_t sat_round(input logic [DEF_DATA_W-1:0] q, input int shift);
        logic signed [DEF_DATA_W:0] qx;
        logic signed [DEF_DATA_W:0] rnd;
        logic signed [DEF_DATA_W:0] t;
        sample_t                    r;
        qx  = signed'({q[DEF_DATA_W-1], q});
        rnd = '0;
        if (shift > 0) begin
            rnd = (DEF_DATA_W+1)'(1) << (shift - 1);
            t   = (qx + rnd) >>> shift;
        end else begin
            t = qx;
        end
        if (t > SAT_MAX) begin
            r.sat  = 1'b1;
            r.data = SAT_MAX[DEF_OUT_W-1:0];
        end else if (t < SAT_MIN) begin
            r.sat  = 1'b1;
            r.data = SAT_MIN[DEF_OUT_W-1:0];
        end else begin
            r.sat  = 1'b0;
            r.data = t[DEF_OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_reader_skid_fifo.sv
// Two-entry first-word-fall-through FIFO holding processed samples between the
// memory read pipeline and the streaming output.
module fir_reader_skid_fifo
    import fir_out_mem_reader_pkg::*;
#(
    parameter int W = DEF_OUT_W + 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic         wr_ptr;
    logic         rd_ptr;

    // Head entry is always visible on dout.
    assign dout = rd_ptr ? slot1 : slot0;

    // Storage, pointers and occupancy; caller guarantees no push when full.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            slot0  <= '0;
            slot1  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) slot1 <= din;
                else        slot0 <= din;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_mem_reader.sv
// Readback engine for the 256x22 filter-output memory: reads a wrap-around
// address range, rounds/shifts/saturates each word and streams it out.
//
// Handshake: a sample transfers on every clk20 edge where dout_valid and
// dout_ready are both high; dout/sat_flag stay stable while dout_valid is high
// and dout_ready is low, and dout_valid only falls after a transfer.
module fir_out_mem_reader
    import fir_out_mem_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic              clk20,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              mem_nce,
    output logic              mem_nwrt,
    output logic [RA_W-1:0]   mem_ra,
    output logic [CA_W-1:0]   mem_ca,
    input  logic [DATA_W-1:0] mem_q,
    output logic [OUT_W-1:0]  dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              sat_flag,
    output logic [1:0]        state_dbg
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] last_addr;
    logic [LEN_W-1:0]  remaining;
    logic              pending;     // read sampled by memory last edge, data on mem_q now
    logic [1:0]        fifo_count;
    logic [OUT_W:0]    fifo_dout;
    logic [OUT_W:0]    proc;
    logic [2:0]        occ;
    logic              pop;
    logic              issue;

    // Processing happens before the FIFO so the FIFO holds {sat, sample}.
    assign proc = sat_round(mem_q, SHIFT);

    fir_reader_skid_fifo #(
        .W (OUT_W + 1)
    ) u_fifo (
        .clk   (clk20),
        .rstn  (rstn),
        .push  (pending),
        .din   (proc),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    // Credit check: FIFO entries plus the read in flight, less this cycle's
    // pop, must leave room for one more word two edges from now.
    always_comb begin
        pop   = dout_valid && dout_ready;
        occ   = {1'b0, fifo_count} + {2'b00, pending};
        issue = (state == ST_READ) && (remaining != '0) && (occ < (3'd2 + {2'b00, pop}));
    end

    // Memory port, stream outputs and status decode.
    always_comb begin
        mem_nce    = ~issue;
        mem_nwrt   = 1'b1;
        {mem_ra, mem_ca} = issue ? addr : last_addr;
        dout_valid = (fifo_count != 2'd0);
        dout       = fifo_dout[OUT_W-1:0];
        sat_flag   = fifo_dout[OUT_W];
        busy       = (state != ST_IDLE);
        done       = (state == ST_FINISH);
        state_dbg  = state;
    end

    // Control FSM, address/length counters and the one-deep read pipeline.
    always_ff @(posedge clk20) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            addr      <= '0;
            last_addr <= '0;
            remaining <= '0;
            pending   <= 1'b0;
        end else begin
            pending <= issue;
            if (issue) begin
                addr      <= addr + 8'd1;
                remaining <= remaining - 9'd1;
                last_addr <= addr;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr      <= start_addr;
                        remaining <= length;
                        state     <= (length == '0) ? ST_FINISH : ST_READ;
                    end
                end
                ST_READ: begin
                    if (remaining == '0) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if ((fifo_count == 2'd0) && !pending) state <= ST_FINISH;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_out_mem_reader.sv
// Directed + randomized bench for fir_out_mem_reader with a behavioural memory
// and an arithmetic reference model.
module tb_fir_out_mem_reader;

    localparam int SH = 6;

    logic        clk20 = 1'b0;
    logic        rstn;
    logic        start;
    logic [7:0]  start_addr;
    logic [8:0]  length;
    logic        busy, done, mem_nce, mem_nwrt;
    logic [5:0]  mem_ra;
    logic [1:0]  mem_ca;
    logic [21:0] mem_q = '0;
    logic [15:0] dout;
    logic        dout_valid, dout_ready, sat_flag;
    logic [1:0]  state_dbg;

    logic [21:0] mem_arr [256];

    int n_checks = 0;
    int n_fail   = 0;
    int iss_cnt  = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    bit prev_stall = 0;
    logic [16:0] prev_out;

    logic [16:0] exp_q [$];
    logic [16:0] obs_q [$];
    logic [7:0]  iss_q [$];

    // clock/reset block
    always #5 clk20 = ~clk20;

    fir_out_mem_reader dut (
        .clk20      (clk20),
        .rstn       (rstn),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .mem_nce    (mem_nce),
        .mem_nwrt   (mem_nwrt),
        .mem_ra     (mem_ra),
        .mem_ca     (mem_ca),
        .mem_q      (mem_q),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .sat_flag   (sat_flag),
        .state_dbg  (state_dbg)
    );

    // Synchronous-read memory: data appears after the edge that samples nce low.
    always @(posedge clk20) begin
        if (!mem_nce) mem_q <= mem_arr[{mem_ra, mem_ca}];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: floor((w + 2^(SH-1)) / 2^SH), then clip to 16-bit signed.
    function automatic logic [16:0] model(input logic [21:0] w);
        int v, num, t;
        v   = int'($signed(w));
        num = v + (1 << (SH - 1));
        if (num >= 0) t = num / (1 << SH);
        else          t = -((-num + (1 << SH) - 1) / (1 << SH));
        if (t > 32767)  return {1'b1, 16'h7FFF};
        if (t < -32768) return {1'b1, 16'h8000};
        return {1'b0, t[15:0]};
    endfunction

    // Scoreboard / protocol monitor
    always @(negedge clk20) begin
        if (!rstn) begin
            iss_cnt    = 0;
            xfer_cnt   = 0;
            prev_stall = 0;
        end else begin
            if (done) done_cnt++;
            if (prev_stall) begin
                check("hold_valid", 32'(dout_valid), 32'd1);
                check("hold_data", 32'({sat_flag, dout}), 32'(prev_out));
            end
            if (!mem_nce) begin
                iss_cnt++;
                iss_q.push_back({mem_ra, mem_ca});
            end
            if (dout_valid && dout_ready) begin
                xfer_cnt++;
                obs_q.push_back({sat_flag, dout});
                if (exp_q.size() == 0) check("out_avail", 32'(exp_q.size() != 0), 32'd1);
                else                   check("out_data", 32'({sat_flag, dout}), 32'(exp_q.pop_front()));
            end
            if (!mem_nce) check("outstanding", 32'((iss_cnt - xfer_cnt) <= 2), 32'd1);
            prev_stall = dout_valid && !dout_ready;
            prev_out   = {sat_flag, dout};
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk20);
        #1;
    endtask

    task automatic start_run(input logic [7:0] sa, input int len);
        for (int i = 0; i < len; i++) exp_q.push_back(model(mem_arr[8'(int'(sa) + i)]));
        iss_q.delete();
        obs_q.delete();
        start      = 1'b1;
        start_addr = sa;
        length     = 9'(len);
        tick();
        start      = 1'b0;
    endtask

    task automatic finish_run(input int budget, input string tag);
        int n;
        n = 0;
        dout_ready = 1'b1;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        tick();
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        check({tag, "_exp_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_nce"},   32'(mem_nce), 32'd1);
        check({tag, "_nwrt"},  32'(mem_nwrt), 32'd1);
        check({tag, "_ra"},    32'(mem_ra), 32'd0);
        check({tag, "_ca"},    32'(mem_ca), 32'd0);
        check({tag, "_dout"},  32'(dout), 32'd0);
        check({tag, "_valid"}, 32'(dout_valid), 32'd0);
        check({tag, "_sat"},   32'(sat_flag), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n;
        int ra_t [4];
        int ca_t [4];
        logic [15:0] ar_dout [5];
        logic        ar_sat [5];
        logic [0:3]  pat;

        rstn = 1'b0; start = 1'b0; start_addr = '0; length = '0; dout_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem_arr[i] = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rstn = 1'b1;
        tick();

        // Full sweep: word i = 64*i streams out as i, one per cycle
        for (int i = 0; i < 256; i++) mem_arr[i] = 22'(64 * i);
        dout_ready = 1'b1;
        d0 = done_cnt;
        start_run(8'd0, 256);
        check("sweep_busy_rise", 32'(busy), 32'd1);
        check("sweep_lat0", 32'(dout_valid), 32'd0);
        tick();
        check("sweep_lat1", 32'(dout_valid), 32'd0);
        tick();
        check("sweep_lat2", 32'(dout_valid), 32'd1);
        for (int i = 0; i < 255; i++) begin
            tick();
            check("sweep_stream", 32'(dout_valid), 32'd1);
        end
        finish_run(20, "sweep");
        check("sweep_done_once", 32'(done_cnt - d0), 32'd1);
        check("sweep_count", 32'(obs_q.size()), 32'd256);
        for (int i = 0; i < 256 && i < obs_q.size(); i++) check("sweep_value", 32'(obs_q[i]), 32'(i));

        // Wrap-around addressing
        for (int i = 0; i < 256; i++) mem_arr[i] = 22'($urandom);
        ra_t = '{63, 63, 0, 0};
        ca_t = '{2, 3, 0, 1};
        start_run(8'd254, 4);
        finish_run(20, "wrap");
        check("wrap_issues", 32'(iss_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < iss_q.size(); i++) begin
            check("wrap_ra", 32'(iss_q[i][7:2]), 32'(ra_t[i]));
            check("wrap_ca", 32'(iss_q[i][1:0]), 32'(ca_t[i]));
        end

        // Arithmetic corner cases
        mem_arr[100] = 22'h1FFFFF;
        mem_arr[101] = 22'h200000;
        mem_arr[102] = 22'(-96);
        mem_arr[103] = 22'd31;
        mem_arr[104] = 22'd32;
        ar_dout = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h0001};
        ar_sat  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        start_run(8'd100, 5);
        finish_run(20, "arith");
        check("arith_count", 32'(obs_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            check("arith_dout", 32'(obs_q[i][15:0]), 32'(ar_dout[i]));
            check("arith_sat", 32'(obs_q[i][16]), 32'(ar_sat[i]));
        end

        // Backpressure: fixed 1-0-0-1 pattern, then random ready
        for (int i = 0; i < 256; i++)
            mem_arr[i] = ($urandom_range(0, 1) == 1) ? 22'($urandom)
                                                      : 22'(int'($urandom_range(0, 4095)) - 2048);
        pat = 4'b1001;
        start_run(8'd30, 8);
        n = 0;
        while (!done && n < 200) begin
            dout_ready = pat[n % 4];
            tick();
            n++;
        end
        finish_run(20, "bp_fixed");
        check("bp_fixed_count", 32'(obs_q.size()), 32'd8);

        start_run(8'($urandom_range(0, 255)), 20);
        n = 0;
        while (!done && n < 400) begin
            dout_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        finish_run(20, "bp_rand");
        check("bp_rand_count", 32'(obs_q.size()), 32'd20);

        // length = 0
        dout_ready = 1'b1;
        d0 = done_cnt;
        start_run(8'd5, 0);
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd1);
        tick();
        check("len0_done_fall", 32'(done), 32'd0);
        check("len0_busy_fall", 32'(busy), 32'd0);
        check("len0_no_read", 32'(iss_q.size()), 32'd0);
        check("len0_no_out", 32'(obs_q.size()), 32'd0);
        check("len0_done_once", 32'(done_cnt - d0), 32'd1);

        // Start while busy is ignored
        start_run(8'd20, 10);
        tick();
        tick();
        start = 1'b1; start_addr = 8'd200; length = 9'd3;
        tick();
        start = 1'b0;
        finish_run(40, "busy_start");
        check("busy_start_reads", 32'(iss_q.size()), 32'd10);
        check("busy_start_outs", 32'(obs_q.size()), 32'd10);

        // Reset mid-run, then a clean restart
        start_run(8'd60, 10);
        n = 0;
        while (xfer_cnt < 3 && n < 50) begin
            tick();
            n++;
        end
        check("midrst_reached3", 32'(xfer_cnt >= 3), 32'd1);
        d0 = done_cnt;
        rstn = 1'b0;
        tick();
        check_reset_outputs("midrst");
        tick();
        exp_q.delete();
        rstn = 1'b1;
        tick();
        tick();
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        start_run(8'd128, 6);
        finish_run(30, "restart");
        check("restart_count", 32'(obs_q.size()), 32'd6);
        check("restart_first_addr", 32'(iss_q.size() > 0 ? iss_q[0] : 8'd0), 32'd128);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
